vga_timing_gen: RTL

- Parametrised VGA timing generator; replaces the fixed-mode sync pulse and porch blocks with one unit.
- Produces pixel column/row counters, HS/VS with configurable porches, widths and polarity, and an active-video flag.
- Adds a programmable output delay so syncs align with a pattern generator of known latency.
- Sits between the board clock and the pattern generator in the VGA top level.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_timing_gen_if.sv | 12 +
 rtl/vga_axis_counter.sv | 40 ++++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: mode tables, polarity constants, total helper.
package vga_pkg;

   localparam bit POL_LOW  = 1'b0;
   localparam bit POL_HIGH = 1'b1;

   typedef enum logic {MODE_640X480, MODE_800X600} vga_mode_e;

   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
      bit hs_pol;
      bit vs_pol;
   } vga_timing_t;

   // Standard 60 Hz mode timings.
   function automatic vga_timing_t mode_cfg(vga_mode_e m);
      vga_timing_t t;
      if (m == MODE_800X600) begin
         t = '{h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
               v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23,
               hs_pol: POL_HIGH, vs_pol: POL_HIGH};
      end else begin
         t = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
               v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33,
               hs_pol: POL_LOW, vs_pol: POL_LOW};
      end
      return t;
   endfunction

   // Total count of one axis (pixels per line or lines per frame).
   function automatic int axis_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

   localparam vga_timing_t MODE_DEF = mode_cfg(MODE_640X480);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Per-axis counter bundle: the counter owns count/decode, the parent owns advance/clear.
interface vga_timing_gen_if #(parameter int CNT_W = 10);
   logic             adv;
   logic             clr;
   logic [CNT_W-1:0] cnt;
   logic             wrap;
   logic             sync;
   logic             act;

   modport master (input adv, clr, output cnt, wrap, sync, act);
   modport slave  (output adv, clr, input cnt, wrap, sync, act);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus active and sync window decode.
// The sync output already carries the pin level (polarity applied here).
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = MODE_DEF.h_active,
   parameter int FP     = MODE_DEF.h_fp,
   parameter int SYNC   = MODE_DEF.h_sync,
   parameter int BP     = MODE_DEF.h_bp,
   parameter bit POL    = POL_LOW,
   parameter int CNT_W  = 10
) (
   input logic               clk,
   input logic               rst_n,
   vga_timing_gen_if.master  ax
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   // One extra bit so window ends equal to 2^CNT_W do not alias to zero.
   localparam logic [CNT_W:0] LAST    = (CNT_W+1)'(TOTAL - 1);
   localparam logic [CNT_W:0] ACT_END = (CNT_W+1)'(ACTIVE);
   localparam logic [CNT_W:0] SYNC_LO = (CNT_W+1)'(ACTIVE + FP);
   localparam logic [CNT_W:0] SYNC_HI = (CNT_W+1)'(ACTIVE + FP + SYNC);

   logic [CNT_W:0] cnt_x;

   assign cnt_x   = {1'b0, ax.cnt};
   assign ax.wrap = (cnt_x == LAST);
   assign ax.act  = (cnt_x < ACT_END);
   assign ax.sync = ((cnt_x >= SYNC_LO) && (cnt_x < SYNC_HI)) ? POL : ~POL;

   // Count on advance, wrap at TOTAL-1, clear wins over advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ax.cnt <= '0;
      else if (ax.clr) ax.cnt <= '0;
      else if (ax.adv) ax.cnt <= ax.wrap ? '0 : ax.cnt + 1'b1;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: column/row counters, line/frame pulses,
// and HS/VS/active outputs delayed OUT_DLY+1 pixel strobes.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = MODE_DEF.h_active,
   parameter int H_FP     = MODE_DEF.h_fp,
   parameter int H_SYNC   = MODE_DEF.h_sync,
   parameter int H_BP     = MODE_DEF.h_bp,
   parameter int V_ACTIVE = MODE_DEF.v_active,
   parameter int V_FP     = MODE_DEF.v_fp,
   parameter int V_SYNC   = MODE_DEF.v_sync,
   parameter int V_BP     = MODE_DEF.v_bp,
   parameter bit HS_POL   = MODE_DEF.hs_pol,
   parameter bit VS_POL   = MODE_DEF.vs_pol,
   parameter int CNT_W    = 10,
   parameter int OUT_DLY  = 2
) (
   input  logic             CLK,
   input  logic             i_Rst_n,
   input  logic             i_En,
   input  logic             i_Pix_En,
   output logic [CNT_W-1:0] o_Col,
   output logic [CNT_W-1:0] o_Row,
   output logic             o_Line_Start,
   output logic             o_Frame_Start,
   output logic             o_HS,
   output logic             o_VS,
   output logic             o_Active
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [OUT_DLY:0] HS_IDLE = {(OUT_DLY+1){~HS_POL}};
   localparam logic [OUT_DLY:0] VS_IDLE = {(OUT_DLY+1){~VS_POL}};

   if (H_SYNC <= 0 || V_SYNC <= 0) begin : g_bad_sync
      $fatal(1, "vga_timing_gen: H_SYNC and V_SYNC must be > 0");
   end
   if ((2**CNT_W) < H_TOTAL || (2**CNT_W) < V_TOTAL) begin : g_bad_cnt_w
      $fatal(1, "vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
   end
   if (OUT_DLY < 0 || OUT_DLY > 7) begin : g_bad_dly
      $fatal(1, "vga_timing_gen: OUT_DLY must be 0..7");
   end

   vga_timing_gen_if #(.CNT_W(CNT_W)) h_ax ();
   vga_timing_gen_if #(.CNT_W(CNT_W)) v_ax ();

   logic             pix_go;
   logic             run;
   logic [OUT_DLY:0] hs_pipe;
   logic [OUT_DLY:0] vs_pipe;
   logic [OUT_DLY:0] vld_pipe;

   assign pix_go   = i_En & i_Pix_En;
   assign h_ax.adv = pix_go;
   assign h_ax.clr = ~i_En;
   assign v_ax.adv = pix_go & h_ax.wrap;
   assign v_ax.clr = ~i_En;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
      .POL(HS_POL), .CNT_W(CNT_W)
   ) u_h_cnt (
      .clk(CLK), .rst_n(i_Rst_n), .ax(h_ax)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
      .POL(VS_POL), .CNT_W(CNT_W)
   ) u_v_cnt (
      .clk(CLK), .rst_n(i_Rst_n), .ax(v_ax)
   );

   // Set after the first advance so the (0,0) seen right after reset or
   // re-enable does not produce a start pulse.
   always_ff @(posedge CLK or negedge i_Rst_n) begin
      if (!i_Rst_n)      run <= 1'b0;
      else if (!i_En)    run <= 1'b0;
      else if (i_Pix_En) run <= 1'b1;
   end

   assign o_Line_Start  = run & pix_go & (h_ax.cnt == '0);
   assign o_Frame_Start = o_Line_Start & (v_ax.cnt == '0);

   // Decode register plus OUT_DLY stages, all advancing on the pixel strobe.
   always_ff @(posedge CLK or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         hs_pipe  <= HS_IDLE;
         vs_pipe  <= VS_IDLE;
         vld_pipe <= '0;
      end else if (!i_En) begin
         hs_pipe  <= HS_IDLE;
         vs_pipe  <= VS_IDLE;
         vld_pipe <= '0;
      end else if (i_Pix_En) begin
         hs_pipe[0]  <= h_ax.sync;
         vs_pipe[0]  <= v_ax.sync;
         vld_pipe[0] <= h_ax.act & v_ax.act;
         for (int i = 1; i <= OUT_DLY; i++) begin
            hs_pipe[i]  <= hs_pipe[i-1];
            vs_pipe[i]  <= vs_pipe[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   assign o_Col    = h_ax.cnt;
   assign o_Row    = v_ax.cnt;
   assign o_HS     = hs_pipe[OUT_DLY];
   assign o_VS     = vs_pipe[OUT_DLY];
   assign o_Active = vld_pipe[OUT_DLY];

endmodule
